// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in clk cycles.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to compile in the FILTER_CYCLES stability filter.
module pwm_capture #(
    parameter int unsigned SYS_FREQ       = 100000000,
    parameter int unsigned PULSE_FREQ     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 2 * (SYS_FREQ / PULSE_FREQ),
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    parameter int unsigned FILTER_CYCLES  = 4,
`endif
    localparam int unsigned CNT_BITS      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pwm_in,
    output logic [CNT_BITS-1:0] high_time,
    output logic [CNT_BITS-1:0] period,
    output logic                valid,
    output logic                no_signal
);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    state_t              state;
    logic                s1;
    logic                s2;
    logic                p;
    logic                p_d;
    logic                rise;
    logic                fall;
    logic                timeout;
    logic [CNT_BITS-1:0] per_cnt;
    logic [CNT_BITS-1:0] hi_cnt;

    // Two-flop synchronizer for the asynchronous input
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int unsigned FLT_BITS = $clog2(FILTER_CYCLES + 1);

    logic [FLT_BITS-1:0] flt_cnt;

    // p follows s2 only once s2 has disagreed with it for FILTER_CYCLES cycles in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            p       <= 1'b0;
            flt_cnt <= '0;
        end else if (s2 == p) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FLT_BITS'(FILTER_CYCLES - 1)) begin
            p       <= s2;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + FLT_BITS'(1);
        end
    end
`else
    assign p = s2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            p_d <= 1'b0;
        end else begin
            p_d <= p;
        end
    end

    assign rise    = p & ~p_d;
    assign fall    = ~p & p_d;
    assign timeout = (per_cnt >= CNT_BITS'(TIMEOUT_CYCLES));

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == {CNT_BITS{1'b1}}) ? v : v + CNT_BITS'(1);
    endfunction

    // Measurement FSM; a closing rise outranks a coincident timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_RISE;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            high_time <= '0;
            period    <= '0;
            valid     <= 1'b0;
            no_signal <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        state     <= HIGH;
                        per_cnt   <= CNT_BITS'(1);
                        hi_cnt    <= CNT_BITS'(1);
                        no_signal <= 1'b0;
                    end
                end
                HIGH: begin
                    if (timeout) begin
                        state     <= WAIT_RISE;
                        per_cnt   <= '0;
                        hi_cnt    <= '0;
                        no_signal <= 1'b1;
                    end else if (fall) begin
                        state   <= LOW;
                        per_cnt <= sat_inc(per_cnt);
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                        hi_cnt  <= sat_inc(hi_cnt);
                    end
                end
                LOW: begin
                    if (rise) begin
                        state     <= HIGH;
                        high_time <= hi_cnt;
                        period    <= per_cnt;
                        valid     <= 1'b1;
                        per_cnt   <= CNT_BITS'(1);
                        hi_cnt    <= CNT_BITS'(1);
                    end else if (timeout) begin
                        state     <= WAIT_RISE;
                        per_cnt   <= '0;
                        hi_cnt    <= '0;
                        no_signal <= 1'b1;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                    end
                end
                default: begin
                    state   <= WAIT_RISE;
                    per_cnt <= '0;
                    hi_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time and period in system-clock cycles. It is the receive-side counterpart of the PWM serializer. It sits between an external PWM source (servo feedback line, loopback of our own PWM output) and the processor's memory-mapped I/O. It synchronizes the asynchronous input, detects edges and measures each complete period. It also flags loss of signal when no rising edge arrives within a timeout window.

## Interface
- SYS_FREQ, 100000000, system clock frequency in Hz
- PULSE_FREQ, 50, nominal PWM frequency in Hz; PULSE_WINDOW = SYS_FREQ/PULSE_FREQ
- TIMEOUT_CYCLES, 2*PULSE_WINDOW, cycles without a rising edge before loss of signal is declared
- FILTER_CYCLES, 4, glitch-filter stability length (used only when the filter is compiled in)
- Derived: CNT_BITS = $clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- pwm_in  input  1  asynchronous PWM input
- high_time  output  CNT_BITS  cycles the input was high in the last complete period
- period  output  CNT_BITS  cycles between the last two accepted rising edges
- valid  output  1  one-cycle pulse when high_time/period update
- no_signal  output  1  level; high while the input is timed out

## Operation
- Input path: 2-flop synchronizer (s1, s2), then optional filter giving `p`, then history flop `p_d`. rise = p & ~p_d; fall = ~p & p_d.
- Counters: per_cnt counts every cycle in HIGH/LOW; hi_cnt counts cycles in HIGH. Both saturate at 2^CNT_BITS-1.
- FSM states:
  - WAIT_RISE: counters held at 0. Entered on reset or timeout. On rise → HIGH, per_cnt=1, hi_cnt=1.
  - HIGH: per_cnt++, hi_cnt++. On fall → LOW. On per_cnt reaching TIMEOUT_CYCLES → timeout.
  - LOW: per_cnt++. On rise: high_time<=hi_cnt, period<=per_cnt, valid<=1, per_cnt<=1, hi_cnt<=1, → HIGH. On per_cnt reaching TIMEOUT_CYCLES → timeout.
- Timeout: no_signal<=1, counters cleared, → WAIT_RISE. high_time and period keep their last values.
- no_signal clears on the next accepted rise, in the same cycle the FSM enters HIGH.
- The first partial period after reset or timeout is never reported. The first valid requires two accepted rises.
- Measured values are exact cycle counts of the filtered signal: a 30-high/70-low input gives high_time=30, period=100.

## Timing
- Reset values: high_time=0, period=0, valid=0, no_signal=0, FSM=WAIT_RISE, s1/s2/p/p_d=0.
- Latency without filter: valid asserts on the 3rd posedge after the first posedge that samples pwm_in high, for the closing rise. It stays high for exactly 1 cycle.
- Latency with filter: the filter adds FILTER_CYCLES cycles to both edges, so measured widths are unchanged.
- high_time and period change only in the cycle valid is high. They are stable otherwise.
- Reset asserted mid-period: all outputs return to reset values on the next posedge, and any partial measurement is discarded.
- Timeout and rise in the same cycle: the rise wins. The measurement is reported and no timeout occurs.
- Constant high or constant low input: timeout after TIMEOUT_CYCLES. valid never pulses.
- Minimum measurable high or low: 1 cycle of `p`.

## Configuration
- PWM_CAPTURE_GLITCH_FILTER_EN defined:
  - `p` changes to the value of s2 only after s2 has held that value for FILTER_CYCLES consecutive cycles.
  - Pulses shorter than FILTER_CYCLES are ignored.
- Not defined: `p` = s2 directly. Every synchronized edge is measured, including glitches.

## Test plan
Bench parameters: SYS_FREQ=1000, PULSE_FREQ=10, giving PULSE_WINDOW=100, TIMEOUT_CYCLES=200, CNT_BITS=8.
- Reset, then repeat 30 high/70 low → no valid before the 2nd rise. Every later valid shows high_time=30, period=100, and valids are exactly 100 cycles apart.
- After a steady 30/70 stream, hold pwm_in low → no_signal=1 exactly 200 cycles after the last accepted rise. The outputs keep 30/100, and no_signal clears on the next rise.
- Hold pwm_in high from reset → no valid, and no_signal=1 after 200 cycles from the rise.
- Switch from 30/70 to 10/40 mid-stream → the next valid reports 30/100. The following valids report 10/50.
- Assert reset for 1 cycle at cycle 50 of a period → all outputs are 0. The first new valid comes after two more rises with correct values.
- Inject a 2-cycle low glitch inside a 30-cycle high:
  - With PWM_CAPTURE_GLITCH_FILTER_EN: high_time=30, period=100.
  - Without: the glitch splits the period, and the next valid reports the truncated high_time.
